// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter4
// Description : Four-requester round-robin arbiter with a per-line debounce
//               qualifier ahead of the grant state machine.
// Revision    : 1.0 - initial release
// ============================================================================

module rr_arbiter4 #(
  parameter int DEB = 3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] req,
  input  logic       en,
  output logic [3:0] gnt,
  output logic [1:0] id,
  output logic       valid,
  output logic       busy_n
);

  localparam logic [3:0] c_deb_last  = 4'(DEB - 1);
  localparam logic [0:0] c_st_idle   = 1'b0;
  localparam logic [0:0] c_st_grant  = 1'b1;

  logic [3:0] w_q;

  // A line's filtered level only moves after DEB consecutive disagreeing samples.
  for (genvar gi = 0; gi < 4; gi++) begin : g_chan
    logic       r_q;
    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
      if (clr) begin
        r_q   <= 1'b0;
        r_cnt <= 4'd0;
      end else if (req[gi] == r_q) begin
        r_cnt <= 4'd0;
      end else if (r_cnt == c_deb_last) begin
        r_q   <= req[gi];
        r_cnt <= 4'd0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end

    assign w_q[gi] = r_q;
  end

  logic [0:0] r_state;
  logic [0:0] w_state_nxt;
  logic [1:0] r_ptr;
  logic [1:0] w_ptr_nxt;
  logic [3:0] r_gnt;
  logic [3:0] w_gnt_nxt;
  logic [1:0] r_id;
  logic [1:0] w_id_nxt;
  logic       r_valid;
  logic       r_busy_n;

  logic       w_win_found;
  logic [1:0] w_win_id;
  logic [1:0] w_idx;

  // Search starts one past the last released requester and wraps modulo 4.
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = r_ptr;
    w_idx       = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_win_found && w_q[w_idx]) begin
        w_win_found = 1'b1;
        w_win_id    = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (en && w_win_found) begin
          w_state_nxt = c_st_grant;
        end
      end
      c_st_grant: begin
        if (!w_q[r_id]) begin
          w_state_nxt = c_st_idle;
        end
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    w_gnt_nxt = r_gnt;
    w_id_nxt  = r_id;
    w_ptr_nxt = r_ptr;
    case (r_state)
      c_st_idle: begin
        if (en && w_win_found) begin
          w_gnt_nxt = 4'b0001 << w_win_id;
          w_id_nxt  = w_win_id;
        end else begin
          w_gnt_nxt = 4'b0000;
          w_id_nxt  = 2'd0;
        end
      end
      c_st_grant: begin
        // The holder keeps the grant until its own filtered line drops.
        if (!w_q[r_id]) begin
          w_gnt_nxt = 4'b0000;
          w_id_nxt  = 2'd0;
          w_ptr_nxt = r_id;
        end
      end
      default: begin
        w_gnt_nxt = 4'b0000;
        w_id_nxt  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_gnt    <= 4'b0000;
      r_id     <= 2'd0;
      r_ptr    <= 2'd3;
      r_valid  <= 1'b0;
      r_busy_n <= 1'b1;
    end else begin
      r_gnt    <= w_gnt_nxt;
      r_id     <= w_id_nxt;
      r_ptr    <= w_ptr_nxt;
      r_valid  <= |w_gnt_nxt;
      r_busy_n <= ~(|w_gnt_nxt);
    end
  end

  assign gnt    = r_gnt;
  assign id     = r_id;
  assign valid  = r_valid;
  assign busy_n = r_busy_n;

endmodule

`default_nettype wire
